// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } ovl_mode_e;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Low 'len' bits set; callers truncate to their pattern width.
  function automatic logic [31:0] len_mask(input int unsigned len);
    if (len >= 32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Bit history shift register with a saturating fill counter.
module seq_det_hist #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned FILL_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               accept_i,
  input  logic               x_i,
  input  logic               clear_i,
  output logic [MAX_LEN-1:0] hist_nxt_o,
  output logic [FILL_W-1:0]  fill_nxt_o
);

  logic [MAX_LEN-1:0] hist_q;
  logic [FILL_W-1:0]  fill_q;

  always_comb begin
    hist_nxt_o = {hist_q[MAX_LEN-2:0], x_i};
    fill_nxt_o = fill_q;
    if (fill_q != FILL_W'(MAX_LEN)) fill_nxt_o = fill_q + 1'b1;
  end

  // Clear wins over accept so a non-overlapping match restarts from empty.
  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (accept_i) begin
      hist_q <= hist_nxt_o;
      fill_q <= fill_nxt_o;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial sequence detector with registered match pulse
// and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               clr_count,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  ovl_mode_e          ovl_q;
  logic               cfg_err_q;
  logic               z_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               match;
  logic               hist_clear;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] mask;

  assign accept     = in_valid && !cfg_load && !cfg_err_q;
  assign mask       = MAX_LEN'(len_mask(int'(len_q)));
  assign match      = accept && (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & mask) == '0);
  assign hist_clear = cfg_load || (match && (ovl_q == MODE_NONOVL));

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_hist (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept_i   (accept),
    .x_i        (x),
    .clear_i    (hist_clear),
    .hist_nxt_o (hist_nxt),
    .fill_nxt_o (fill_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q     <= '0;
      len_q     <= LEN_W'(MAX_LEN);
      ovl_q     <= MODE_OVL;
      cfg_err_q <= 1'b0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      z_q <= match;
      if (cfg_load) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        ovl_q     <= ovl_mode_e'(cfg_overlap);
        cfg_err_q <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
      end
      if (clr_count) cnt_q <= '0;
      else if (match && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with CNT_W=2 covers saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       x;
  logic       clr_count;
  logic       z, z2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic       err, err2;

  int total = 0;
  int bad   = 0;

  logic [15:0] zs;
  logic        idle_z;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
    .clr_count(clr_count), .z(z), .match_count(cnt), .cfg_err(err)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
    .clr_count(clr_count), .z(z2), .match_count(cnt2), .cfg_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    @(negedge clk);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  // bits[n-1] is sent first; z after each bit lands in the same position of zs_o.
  task automatic send(input logic [15:0] bits, input int n, input bit gap,
                      output logic [15:0] zs_o, output logic idle_o);
    zs_o   = '0;
    idle_o = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      in_valid = 1'b1;
      x = bits[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      zs_o[i] = z;
      if (gap) begin
        @(posedge clk);
        #1;
        idle_o = idle_o | z;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; x = 1'b0; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("reset_z", {31'd0, z}, 32'd0);
    chk("reset_cnt", {24'd0, cnt}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    // Default config: pattern 0, len 8, overlap.
    send(16'h0000, 8, 0, zs, idle_z);
    chk("default_len8", {16'd0, zs}, 32'h01);

    // 1: overlapping 10011.
    load(8'b10011, 4'd5, 1'b1);
    clear_cnt();
    send(16'b100110011, 9, 0, zs, idle_z);
    chk("t1_z", {16'd0, zs}, 32'b000010001);
    chk("t1_cnt", {24'd0, cnt}, 32'd2);

    // 2: non-overlapping.
    load(8'b10011, 4'd5, 1'b0);
    clear_cnt();
    send(16'b100110011, 9, 0, zs, idle_z);
    chk("t2_z", {16'd0, zs}, 32'b000010000);
    chk("t2_cnt", {24'd0, cnt}, 32'd1);

    // 3: pattern 11.
    load(8'b11, 4'd2, 1'b1);
    send(16'b1111, 4, 0, zs, idle_z);
    chk("t3_ovl", {16'd0, zs}, 32'b0111);
    load(8'b11, 4'd2, 1'b0);
    send(16'b1111, 4, 0, zs, idle_z);
    chk("t3_novl", {16'd0, zs}, 32'b0101);

    // 4: idle gaps between valid bits.
    load(8'b10011, 4'd5, 1'b1);
    send(16'b10011, 5, 1, zs, idle_z);
    chk("t4_z", {16'd0, zs}, 32'b00001);
    chk("t4_idle", {31'd0, idle_z}, 32'd0);

    // 5: illegal lengths, then recovery.
    load(8'h00, 4'd0, 1'b1);
    chk("t5_err_len0", {31'd0, err}, 32'd1);
    send(16'h0000, 8, 0, zs, idle_z);
    chk("t5_z_len0", {16'd0, zs}, 32'd0);
    load(8'hFF, 4'd9, 1'b1);
    chk("t5_err_len9", {31'd0, err}, 32'd1);
    send(16'h00FF, 10, 0, zs, idle_z);
    chk("t5_z_len9", {16'd0, zs}, 32'd0);
    load(8'b101, 4'd3, 1'b1);
    chk("t5_err_clr", {31'd0, err}, 32'd0);
    send(16'b101, 3, 0, zs, idle_z);
    chk("t5_z_101", {16'd0, zs}, 32'b001);

    // 6: saturation on the CNT_W=2 instance, clr vs match, reset mid-sequence.
    do_reset();
    load(8'b1, 4'd1, 1'b1);
    send(16'b111111, 6, 0, zs, idle_z);
    chk("t6_z", {16'd0, zs}, 32'b111111);
    chk("t6_sat", {30'd0, cnt2}, 32'd3);
    chk("t6_cnt8", {24'd0, cnt}, 32'd6);

    @(negedge clk);
    in_valid = 1'b1; x = 1'b1; clr_count = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr_count = 1'b0;
    chk("t6_clr_cnt2", {30'd0, cnt2}, 32'd0);
    chk("t6_clr_cnt", {24'd0, cnt}, 32'd0);
    chk("t6_clr_z", {30'd0, z, z2}, 32'b11);

    load(8'b1, 4'd1, 1'b0);
    send(16'b1011, 4, 0, zs, idle_z);
    chk("t6_len1_novl", {16'd0, zs}, 32'b1011);

    load(8'b10011, 4'd5, 1'b1);
    send(16'b1001, 4, 0, zs, idle_z);
    chk("t6_partial", {16'd0, zs}, 32'd0);
    do_reset();
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    chk("t6_rst_cnt", {24'd0, cnt}, 32'd0);
    load(8'b10011, 4'd5, 1'b1);
    send(16'b1, 1, 0, zs, idle_z);
    chk("t6_after_rst", {16'd0, zs}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
